// File: rtl/regfile_access_ctrl.sv
// Multicycle register-file access controller.
// Latches an instruction on s and sequences reads, loads and one write.
module regfile_access_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic [15:0]       instruction,
    output logic              w,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_REG
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_mvn;
    logic is_alu;
    logic is_cmp;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    assign is_alu     = (opcode == 3'b101) && (op != 2'b11);
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);

    // Datapath fields come straight from the held instruction.
    assign shift  = ir[4:3];
    assign ALUop  = (opcode == 3'b101) ? op : 2'b00;
    assign sximm8 = DATA_W'($signed(ir[7:0]));

    // State register and instruction latch; IR only loads when accepting s.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && s) begin
                ir <= instruction;
            end
        end
    end

    // Next-state and Moore output decode from state and IR.
    always_comb begin
        state_nxt = state;
        w         = 1'b0;
        readnum   = 3'd0;
        writenum  = 3'd0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = 2'b00;
        unique case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_nxt = S_WR_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    state_nxt = S_GET_B;
                end else if (is_alu) begin
                    state_nxt = S_GET_A;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WR_IMM: begin
                writenum  = rn;
                vsel      = 2'b10;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_GET_A: begin
                readnum   = rn;
                loada     = 1'b1;
                state_nxt = S_GET_B;
            end
            S_GET_B: begin
                readnum   = rm;
                loadb     = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                asel = is_mov_reg || is_mvn;
                if (is_cmp) begin
                    loads     = 1'b1;
                    state_nxt = S_WAIT;
                end else begin
                    loadc     = 1'b1;
                    state_nxt = S_WR_REG;
                end
            end
            S_WR_REG: begin
                writenum  = rd;
                vsel      = 2'b00;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            default: begin
                state_nxt = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed and random instructions
// compared cycle by cycle against a micro-op schedule model.
module tb_regfile_access_ctrl;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  vsel;
        logic [1:0]  shift;
        logic [1:0]  ALUop;
        logic [15:0] sximm8;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [15:0] instruction;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;

    int   checks = 0;
    int   errors = 0;
    exp_t act;
    exp_t tr[$];

    regfile_access_ctrl #(.DATA_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .s(s),
        .instruction(instruction),
        .w(w),
        .readnum(readnum),
        .writenum(writenum),
        .write(write),
        .loada(loada),
        .loadb(loadb),
        .loadc(loadc),
        .loads(loads),
        .asel(asel),
        .bsel(bsel),
        .vsel(vsel),
        .shift(shift),
        .ALUop(ALUop),
        .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    assign act = '{w, readnum, writenum, write, loada, loadb, loadc,
                   loads, asel, bsel, vsel, shift, ALUop, sximm8};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input exp_t e, input string tag);
        checks++;
        assert (act === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, act, e);
        end
    endtask

    // Fields any cycle shows for a given held instruction.
    function automatic exp_t base(input logic [15:0] ir);
        exp_t e;
        e        = '0;
        e.shift  = ir[4:3];
        e.ALUop  = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
        e.sximm8 = {{8{ir[7]}}, ir[7:0]};
        return e;
    endfunction

    // Schedule of micro-ops, one entry per cycle after the s edge.
    task automatic build(input logic [15:0] ir);
        exp_t b;
        exp_t e;
        logic [2:0] opc;
        logic [1:0] op;
        opc = ir[15:13];
        op  = ir[12:11];
        b   = base(ir);
        tr.delete();
        tr.push_back(b);
        if (opc == 3'd6 && op == 2'd2) begin
            e = b; e.write = 1; e.writenum = ir[10:8]; e.vsel = 2'b10;
            tr.push_back(e);
        end else if ((opc == 3'd6 && op == 2'd0) ||
                     (opc == 3'd5 && op == 2'd3)) begin
            e = b; e.readnum = ir[2:0]; e.loadb = 1;
            tr.push_back(e);
            e = b; e.asel = 1; e.loadc = 1;
            tr.push_back(e);
            e = b; e.write = 1; e.writenum = ir[7:5];
            tr.push_back(e);
        end else if (opc == 3'd5) begin
            e = b; e.readnum = ir[10:8]; e.loada = 1;
            tr.push_back(e);
            e = b; e.readnum = ir[2:0]; e.loadb = 1;
            tr.push_back(e);
            e = b;
            if (op == 2'd1) e.loads = 1;
            else e.loadc = 1;
            tr.push_back(e);
            if (op != 2'd1) begin
                e = b; e.write = 1; e.writenum = ir[7:5];
                tr.push_back(e);
            end
        end
        e = b; e.w = 1;
        tr.push_back(e);
    endtask

    // Start from WAIT; smode 0 = random s mid-run, 1 = s held high.
    task automatic run_instr(input logic [15:0] ins, input bit smode,
                             input string name);
        s = 1'b1;
        instruction = ins;
        build(ins);
        step();
        for (int i = 0; i < tr.size(); i++) begin
            check(tr[i], $sformatf("%s c%0d", name, i + 1));
            if (i < tr.size() - 1) begin
                s = smode ? 1'b1 : 1'($urandom);
                instruction = 16'($urandom);
                step();
            end
        end
        s = 1'b0;
    endtask

    // Start an instruction, then assert reset while in cycle k.
    task automatic reset_during(input logic [15:0] ins, input int k,
                                input string name);
        exp_t idle;
        int   kk;
        s = 1'b1;
        instruction = ins;
        build(ins);
        kk = (k < tr.size()) ? k : tr.size() - 1;
        step();
        s = 1'b0;
        for (int i = 0; i <= kk; i++) begin
            check(tr[i], $sformatf("%s pre c%0d", name, i + 1));
            if (i < kk) begin
                instruction = 16'($urandom);
                step();
            end
        end
        idle   = base(16'h0000);
        idle.w = 1'b1;
        s      = 1'b1;
        reset  = 1'b1;
        step();
        check(idle, {name, " at_rst"});
        reset = 1'b0;
        s     = 1'b0;
        step();
        check(idle, {name, " after_rst"});
    endtask

    initial begin
        exp_t idle;
        logic [15:0] ins;
        reset = 1'b1;
        s = 1'b1;
        instruction = 16'hD2F5;
        step();
        step();
        idle   = base(16'h0000);
        idle.w = 1'b1;
        check(idle, "reset_hold");
        reset = 1'b0;
        s = 1'b0;
        step();
        check(idle, "reset_idle");

        run_instr(16'hD2F5, 1'b0, "mov_imm");
        run_instr(16'hA0A1, 1'b0, "add");
        run_instr(16'hA901, 1'b0, "cmp");
        run_instr(16'hC0B9, 1'b0, "mov_reg");
        run_instr(16'hB8E2, 1'b0, "mvn");
        run_instr(16'hB0A3, 1'b0, "and");
        run_instr(16'hE000, 1'b0, "illegal");
        run_instr(16'hA0A1, 1'b1, "add_s_held");
        run_instr(16'hD27F, 1'b1, "mov_imm_pos");
        run_instr(16'hC87F, 1'b0, "mov_op01_ill");

        reset_during(16'hA0A1, 4, "rst_wr_reg");
        reset_during(16'hD280, 1, "rst_wr_imm");

        for (int n = 0; n < 60; n++) begin
            ins = 16'($urandom);
            case ($urandom % 4)
                0: ins[15:13] = 3'b110;
                1, 2: ins[15:13] = 3'b101;
                default: ;
            endcase
            if ($urandom % 8 == 0)
                reset_during(ins, int'($urandom_range(0, 5)),
                             $sformatf("rnd_rst%0d", n));
            else
                run_instr(ins, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
